ctrl_pipe: RTL
==============

// Module: ctrl_pipe
// PURPOSE
//   Consumer end of the decode control bundle. Takes the decoded controls for the instruction in
//   ID and carries them through the ID/EX, EX/MEM and MEM/WB stage registers, inserting bubbles
//   and flushes as needed.
//   Detects load-use and RAW hazards, stalls fetch, and squashes wrong-path instructions on taken
//   branches/jumps.
//   Sits between the control unit and the datapath stage registers.
// PARAMETERS
//   NREG   32  register count; rs/rt/RegDst are $clog2(NREG) bits wide; register 0 is never a hazard source
// PORTS
//   CLK            in   1   clock, rising edge
//   nRST           in   1   asynchronous active-low reset
//   ihit           in   1   instruction fetch complete this cycle
//   dhit           in   1   data access in MEM complete this cycle
//   id_valid       in   1   ID holds a real instruction
//   id_ALUSrc      in   2   decoded controls for the ID instruction
//   id_ALUOp       in   4   decoded controls for the ID instruction (aluop_t)
//   id_RegSel      in   2   decoded controls for the ID instruction
//   id_RegWr       in   1   decoded controls for the ID instruction
//   id_ExtOp       in   1   decoded controls for the ID instruction
//   id_dREN        in   1   decoded controls for the ID instruction
//   id_dWEN        in   1   decoded controls for the ID instruction
//   id_PCSrc       in   3   decoded controls for the ID instruction
//   id_RegDst      in   5   decoded controls for the ID instruction (regbits_t)
//   id_rs, id_rt   in   5   source registers of the ID instruction
//   ex_taken       in   1   EX has resolved its PCSrc as redirecting the PC
//   ex_ctrl        out  ctrl_t  ID/EX control register, plus ex_rs and ex_rt (5 bits each)
//   mem_ctrl       out  ctrl_t  EX/MEM control register
//   wb_RegWr       out  1   MEM/WB write enable
//   wb_RegSel      out  2   MEM/WB write-data select
//   wb_RegDst      out  5   MEM/WB destination register
//   stall_if       out  1   hold PC and IF/ID
//   flush_id       out  1   invalidate IF/ID on the next edge
//   fwdA, fwdB     out  2   fwd_t; present only with CTRL_FORWARD_EN
// BEHAVIOUR
//   Reset: all stage registers are cleared to bubble (every control field 0). stall_if=0, flush_id=0, fwdA=fwdB=0.
//     Reset is asynchronous and may occur mid-stall; no state survives it.
//   Bubble: a ctrl_t with RegWr, dREN and dWEN = 0 and PCSrc = 0.
//   Advance: en = ihit & (~(mem_dREN|mem_dWEN) | dhit).
//     When en=0, all three stage registers hold and stall_if=1.
//   Hazard, with CTRL_FORWARD_EN: hz = ex_dREN & ex_RegDst!=0 & (ex_RegDst==id_rs | ex_RegDst==id_rt).
//   Hazard, without CTRL_FORWARD_EN: hz = any of EX or MEM with RegWr=1, RegDst!=0 and
//     RegDst matching id_rs or id_rt.
//     The register file writes WB on the falling edge, so WB is never a hazard.
//   On en & hz: ID/EX loads a bubble, EX/MEM and MEM/WB advance, stall_if=1.
//     The stall lasts 1 cycle for load-use and up to 2 cycles without forwarding.
//   On en & ex_taken: flush_id=1; ID/EX loads a bubble; stall_if=0 so the redirected PC is fetched.
//   Priority: ex_taken beats hz (the stalled instruction is on the wrong path).
//     en=0 beats both: the flush is deferred until en=1, and ex_taken must stay high until then.
//   id_valid=0: ID/EX loads a bubble.
//   Latency: controls appear at EX one edge after acceptance, at MEM after two, at WB after three.
// CONFIGURATION
//   CTRL_FORWARD_EN defined: fwdA/fwdB are driven from ex_rs/ex_rt.
//     01 = forward from MEM when mem_RegWr & mem_RegDst==src & src!=0.
//     10 = forward from WB under the same rule against wb_RegDst.
//     MEM has priority over WB; otherwise 00.
//   CTRL_FORWARD_EN undefined: the fwd ports are absent and the full RAW stall rule above applies.
// STRUCTURE
//   cpu_types_pkg gains:
//     ctrl_t packed struct {ALUSrc, ALUOp, RegSel, RegWr, ExtOp, dREN, dWEN, PCSrc, RegDst}.
//     fwd_t enum {FWD_REG=0, FWD_MEM=1, FWD_WB=2}.
//     BUBBLE constant of type ctrl_t.
//   Sub-module hazard_detect (combinational) computes hz and, under CTRL_FORWARD_EN, the fwd selects.
//   ctrl_pipe holds the registers and the priority logic.
// TESTING
//   1. lw $2 accepted, next ID reads rs=$2, ihit=1:
//      -> one bubble enters EX, stall_if=1 for 1 cycle.
//      -> with CTRL_FORWARD_EN, the consumer later sees fwdA=10.
//   2. add $3 then sub reading $3 with CTRL_FORWARD_EN:
//      -> no stall, fwdA=01 in the consumer's EX cycle.
//      -> without CTRL_FORWARD_EN: stall_if=1 for 2 cycles.
//   3. beq in EX with ex_taken=1 while hz=1:
//      -> flush_id=1, ID/EX=BUBBLE, stall_if=0.
//   4. sw in MEM, dhit=0 for 3 cycles:
//      -> all stage registers frozen, stall_if=1.
//      -> everything advances on the cycle dhit=1.
//   5. nRST low mid-stall:
//      -> all outputs go to 0 asynchronously.
//      -> the first instruction after release passes with no stall.
//   6. Writes to $0 in EX and MEM with ID reading $0:
//      -> no stall, fwd=00.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: decoded control bundle, forwarding selects and the bubble constant.
package cpu_types_pkg;

    localparam int NREG  = 32;
    localparam int REG_W = $clog2(NREG);

    typedef logic [REG_W-1:0] regbits_t;
    typedef logic [3:0]       aluop_t;

    typedef struct packed {
        logic [1:0] ALUSrc;
        aluop_t     ALUOp;
        logic [1:0] RegSel;
        logic       RegWr;
        logic       ExtOp;
        logic       dREN;
        logic       dWEN;
        logic [2:0] PCSrc;
        regbits_t   RegDst;
    } ctrl_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_t;

    localparam ctrl_t BUBBLE = '0;

    // Register 0 is hardwired, so a write to it never creates a dependency.
    function automatic logic reg_match(regbits_t dst, regbits_t a, regbits_t b);
        return (dst != '0) && ((dst == a) || (dst == b));
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard check for the ID instruction; with CTRL_FORWARD_EN it also
// selects the EX operand forwarding sources.
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic     ex_blocks_i,
    input  regbits_t ex_RegDst_i,
    input  logic     mem_RegWr_i,
    input  regbits_t mem_RegDst_i,
    input  regbits_t id_rs_i,
    input  regbits_t id_rt_i,
`ifdef CTRL_FORWARD_EN
    input  regbits_t ex_rs_i,
    input  regbits_t ex_rt_i,
    input  logic     wb_RegWr_i,
    input  regbits_t wb_RegDst_i,
    output fwd_t     fwdA_o,
    output fwd_t     fwdB_o,
`endif
    output logic     hz_o
);

`ifdef CTRL_FORWARD_EN
    function automatic fwd_t fwd_sel(regbits_t src);
        fwd_t sel;
        sel = FWD_REG;
        if (mem_RegWr_i && (src != '0) && (mem_RegDst_i == src)) begin
            sel = FWD_MEM;
        end else if (wb_RegWr_i && (src != '0) && (wb_RegDst_i == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    assign fwdA_o = fwd_sel(ex_rs_i);
    assign fwdB_o = fwd_sel(ex_rt_i);
    assign hz_o   = ex_blocks_i & reg_match(ex_RegDst_i, id_rs_i, id_rt_i);
`else
    assign hz_o = (ex_blocks_i & reg_match(ex_RegDst_i, id_rs_i, id_rt_i))
                | (mem_RegWr_i & reg_match(mem_RegDst_i, id_rs_i, id_rt_i));
`endif

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM and MEM/WB control registers with stall, bubble and flush priority.
// Optional operand forwarding is enabled by defining CTRL_FORWARD_EN.
module ctrl_pipe
    import cpu_types_pkg::*;
(
    input  logic       CLK,
    input  logic       nRST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic       id_valid,
    input  logic [1:0] id_ALUSrc,
    input  aluop_t     id_ALUOp,
    input  logic [1:0] id_RegSel,
    input  logic       id_RegWr,
    input  logic       id_ExtOp,
    input  logic       id_dREN,
    input  logic       id_dWEN,
    input  logic [2:0] id_PCSrc,
    input  regbits_t   id_RegDst,
    input  regbits_t   id_rs,
    input  regbits_t   id_rt,
    input  logic       ex_taken,
    output ctrl_t      ex_ctrl,
    output regbits_t   ex_rs,
    output regbits_t   ex_rt,
    output ctrl_t      mem_ctrl,
    output logic       wb_RegWr,
    output logic [1:0] wb_RegSel,
    output regbits_t   wb_RegDst,
    output logic       stall_if,
    output logic       flush_id
`ifdef CTRL_FORWARD_EN
    ,
    output fwd_t       fwdA,
    output fwd_t       fwdB
`endif
);

    ctrl_t      ex_ctrl_q, ex_ctrl_d;
    regbits_t   ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
    ctrl_t      mem_ctrl_q, mem_ctrl_d;
    logic       wb_RegWr_q, wb_RegWr_d;
    logic [1:0] wb_RegSel_q, wb_RegSel_d;
    regbits_t   wb_RegDst_q, wb_RegDst_d;

    ctrl_t id_ctrl;
    logic  en, hz, squash, ex_blocks;

    assign id_ctrl = '{ALUSrc: id_ALUSrc, ALUOp: id_ALUOp, RegSel: id_RegSel,
                       RegWr: id_RegWr, ExtOp: id_ExtOp, dREN: id_dREN,
                       dWEN: id_dWEN, PCSrc: id_PCSrc, RegDst: id_RegDst};

`ifdef CTRL_FORWARD_EN
    // Only a load in EX has no value ready to forward next cycle.
    assign ex_blocks = ex_ctrl_q.dREN;
`else
    assign ex_blocks = ex_ctrl_q.RegWr;
`endif

    hazard_detect u_hazard (
        .ex_blocks_i  (ex_blocks),
        .ex_RegDst_i  (ex_ctrl_q.RegDst),
        .mem_RegWr_i  (mem_ctrl_q.RegWr),
        .mem_RegDst_i (mem_ctrl_q.RegDst),
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
`ifdef CTRL_FORWARD_EN
        .ex_rs_i      (ex_rs_q),
        .ex_rt_i      (ex_rt_q),
        .wb_RegWr_i   (wb_RegWr_q),
        .wb_RegDst_i  (wb_RegDst_q),
        .fwdA_o       (fwdA),
        .fwdB_o       (fwdB),
`endif
        .hz_o         (hz)
    );

    assign en     = ihit & (~(mem_ctrl_q.dREN | mem_ctrl_q.dWEN) | dhit);
    assign squash = ex_taken | hz | ~id_valid;

    always_comb begin
        ex_ctrl_d   = ex_ctrl_q;
        ex_rs_d     = ex_rs_q;
        ex_rt_d     = ex_rt_q;
        mem_ctrl_d  = mem_ctrl_q;
        wb_RegWr_d  = wb_RegWr_q;
        wb_RegSel_d = wb_RegSel_q;
        wb_RegDst_d = wb_RegDst_q;
        if (en) begin
            if (squash) begin
                ex_ctrl_d = BUBBLE;
                ex_rs_d   = '0;
                ex_rt_d   = '0;
            end else begin
                ex_ctrl_d = id_ctrl;
                ex_rs_d   = id_rs;
                ex_rt_d   = id_rt;
            end
            mem_ctrl_d  = ex_ctrl_q;
            wb_RegWr_d  = mem_ctrl_q.RegWr;
            wb_RegSel_d = mem_ctrl_q.RegSel;
            wb_RegDst_d = mem_ctrl_q.RegDst;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ex_ctrl_q   <= BUBBLE;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            mem_ctrl_q  <= BUBBLE;
            wb_RegWr_q  <= 1'b0;
            wb_RegSel_q <= 2'b00;
            wb_RegDst_q <= '0;
        end else begin
            ex_ctrl_q   <= ex_ctrl_d;
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            mem_ctrl_q  <= mem_ctrl_d;
            wb_RegWr_q  <= wb_RegWr_d;
            wb_RegSel_q <= wb_RegSel_d;
            wb_RegDst_q <= wb_RegDst_d;
        end
    end

    // A taken branch overrides the hazard stall; a frozen pipe defers the flush.
    assign stall_if = nRST & (~en | (hz & ~ex_taken));
    assign flush_id = nRST & en & ex_taken;

    assign ex_ctrl   = ex_ctrl_q;
    assign ex_rs     = ex_rs_q;
    assign ex_rt     = ex_rt_q;
    assign mem_ctrl  = mem_ctrl_q;
    assign wb_RegWr  = wb_RegWr_q;
    assign wb_RegSel = wb_RegSel_q;
    assign wb_RegDst = wb_RegDst_q;

endmodule
